// File: rtl/ship_life_fsm_if.sv
// Signal bundle between the ship life sequencer and its neighbours
// (collision/controller inputs, draw/fire gating outputs).
interface ship_life_fsm_if;
    logic       ShipColl;
    logic       Start;
    logic       ShipAlive;
    logic       ShipVisible;
    logic       ExplodeOn;
    logic [1:0] ExplodeIdx;
    logic [2:0] Lives;
    logic       GameOver;
    logic       ShipHit;
    logic       ShipRespawn;

    modport master (
        output ShipColl, Start,
        input  ShipAlive, ShipVisible, ExplodeOn, ExplodeIdx, Lives,
               GameOver, ShipHit, ShipRespawn
    );

    modport slave (
        input  ShipColl, Start,
        output ShipAlive, ShipVisible, ExplodeOn, ExplodeIdx, Lives,
               GameOver, ShipHit, ShipRespawn
    );
endinterface

// File: rtl/ship_life_fsm.sv
// Per-frame life/respawn sequencer: lives, explosion animation, respawn
// delay and blinking invulnerability window. All outputs are registered.
module ship_life_fsm #(
    parameter int LIVES_INIT  = 3,
    parameter int EXP_STEP_FR = 4,
    parameter int EXP_STEPS   = 4,
    parameter int RESPAWN_FR  = 60,
    parameter int INVULN_FR   = 120,
    parameter int BLINK_HALF  = 4
) (
    input logic            frame_clk,
    input logic            Reset,
    ship_life_fsm_if.slave sl
);
    localparam int EXP_LEN = EXP_STEPS * EXP_STEP_FR;
    localparam int MAX_A   = (EXP_LEN > RESPAWN_FR) ? EXP_LEN : RESPAWN_FR;
    localparam int MAX_LD  = ((MAX_A > INVULN_FR) ? MAX_A : INVULN_FR) - 1;
    localparam int TW      = $clog2(MAX_LD) + 1;
    localparam int MAX_S   = (EXP_STEP_FR > BLINK_HALF) ? EXP_STEP_FR : BLINK_HALF;
    localparam int SW      = $clog2(MAX_S) + 1;
    localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
    localparam logic [1:0] IDX_MAX   = 2'(EXP_STEPS - 1);

    typedef enum logic [2:0] {ALIVE, EXPLODE, RESPAWN_WAIT, INVULN, GAME_OVER} state_t;

    state_t        state, stateNext;
    logic [TW-1:0] timer, timerNext;
    logic [SW-1:0] subCnt, subCntNext;   // explosion step or blink phase counter
    logic          shipAlive, shipAliveNext;
    logic          shipVisible, shipVisibleNext;
    logic          explodeOn, explodeOnNext;
    logic [1:0]    explodeIdx, explodeIdxNext;
    logic [2:0]    lives, livesNext;
    logic          gameOver, gameOverNext;
    logic          shipHit, shipHitNext;
    logic          shipRespawn, shipRespawnNext;
    logic          goInvuln;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= ALIVE;
            timer       <= '0;
            subCnt      <= '0;
            shipAlive   <= 1'b1;
            shipVisible <= 1'b1;
            explodeOn   <= 1'b0;
            explodeIdx  <= 2'd0;
            lives       <= LIVES_RST;
            gameOver    <= 1'b0;
            shipHit     <= 1'b0;
            shipRespawn <= 1'b0;
        end else begin
            state       <= stateNext;
            timer       <= timerNext;
            subCnt      <= subCntNext;
            shipAlive   <= shipAliveNext;
            shipVisible <= shipVisibleNext;
            explodeOn   <= explodeOnNext;
            explodeIdx  <= explodeIdxNext;
            lives       <= livesNext;
            gameOver    <= gameOverNext;
            shipHit     <= shipHitNext;
            shipRespawn <= shipRespawnNext;
        end
    end

    always_comb begin
        stateNext       = state;
        timerNext       = timer;
        subCntNext      = subCnt;
        shipAliveNext   = shipAlive;
        shipVisibleNext = shipVisible;
        explodeOnNext   = explodeOn;
        explodeIdxNext  = explodeIdx;
        livesNext       = lives;
        gameOverNext    = gameOver;
        shipHitNext     = 1'b0;
        shipRespawnNext = 1'b0;
        goInvuln        = 1'b0;

        case (state)
            ALIVE: begin
                if (sl.ShipColl) begin
                    stateNext       = EXPLODE;
                    livesNext       = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
                    shipHitNext     = 1'b1;
                    shipAliveNext   = 1'b0;
                    shipVisibleNext = 1'b0;
                    explodeOnNext   = 1'b1;
                    explodeIdxNext  = 2'd0;
                    timerNext       = TW'(EXP_LEN - 1);
                    subCntNext      = SW'(EXP_STEP_FR - 1);
                end
            end
            EXPLODE: begin
                if (timer == '0) begin
                    explodeOnNext = 1'b0;
                    if (lives == 3'd0) begin
                        stateNext    = GAME_OVER;
                        gameOverNext = 1'b1;
                    end else begin
                        stateNext = RESPAWN_WAIT;
                        timerNext = TW'(RESPAWN_FR - 1);
                    end
                end else begin
                    timerNext = timer - 1'b1;
                    if (subCnt == '0) begin
                        subCntNext = SW'(EXP_STEP_FR - 1);
                        if (explodeIdx < IDX_MAX) explodeIdxNext = explodeIdx + 2'd1;
                    end else begin
                        subCntNext = subCnt - 1'b1;
                    end
                end
            end
            RESPAWN_WAIT: begin
                if (timer == '0) goInvuln  = 1'b1;
                else             timerNext = timer - 1'b1;
            end
            INVULN: begin
                // collisions are deliberately not looked at until back in ALIVE
                if (timer == '0) begin
                    stateNext       = ALIVE;
                    shipVisibleNext = 1'b1;
                end else begin
                    timerNext = timer - 1'b1;
                    if (subCnt == '0) begin
                        subCntNext      = SW'(BLINK_HALF - 1);
                        shipVisibleNext = ~shipVisible;
                    end else begin
                        subCntNext = subCnt - 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                shipAliveNext   = 1'b0;
                shipVisibleNext = 1'b0;
                explodeOnNext   = 1'b0;
                livesNext       = 3'd0;
                gameOverNext    = 1'b1;
                if (sl.Start) begin
                    livesNext    = LIVES_RST;
                    gameOverNext = 1'b0;
                    goInvuln     = 1'b1;
                end
            end
            default: stateNext = ALIVE;
        endcase

        if (goInvuln) begin
            stateNext       = INVULN;
            shipRespawnNext = 1'b1;
            shipAliveNext   = 1'b1;
            shipVisibleNext = 1'b1;
            timerNext       = TW'(INVULN_FR - 1);
            subCntNext      = SW'(BLINK_HALF - 1);
        end
    end

    assign sl.ShipAlive   = shipAlive;
    assign sl.ShipVisible = shipVisible;
    assign sl.ExplodeOn   = explodeOn;
    assign sl.ExplodeIdx  = explodeIdx;
    assign sl.Lives       = lives;
    assign sl.GameOver    = gameOver;
    assign sl.ShipHit     = shipHit;
    assign sl.ShipRespawn = shipRespawn;
endmodule

// File: tb/tb_ship_life_fsm.sv
// Directed bench for ship_life_fsm: hit/explode/respawn/invuln cycle,
// game over and restart, ignored Start, asynchronous reset mid-explosion.
module tb_ship_life_fsm;
    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    ship_life_fsm_if sIf ();

    ship_life_fsm dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .sl        (sIf.slave)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic chkState(input string tag, input int alive, input int vis,
                            input int expOn, input int lives, input int go);
        chk({tag, ".alive"}, int'(sIf.ShipAlive), alive);
        chk({tag, ".vis"},   int'(sIf.ShipVisible), vis);
        chk({tag, ".expOn"}, int'(sIf.ExplodeOn), expOn);
        chk({tag, ".lives"}, int'(sIf.Lives), lives);
        chk({tag, ".gameOver"}, int'(sIf.GameOver), go);
    endtask

    // from a hit frame with Lives>0: explosion, hidden wait, then respawn pulse
    task automatic runExplodeRespawn(input string tag, input int lives);
        for (int i = 0; i < 16; i++) begin
            chk({tag, ".expOn"}, int'(sIf.ExplodeOn), 1);
            chk({tag, ".idx"}, int'(sIf.ExplodeIdx), i / 4);
            chk({tag, ".hit"}, int'(sIf.ShipHit), (i == 0) ? 1 : 0);
            chk({tag, ".alive"}, int'(sIf.ShipAlive), 0);
            tick();
        end
        for (int i = 0; i < 60; i++) begin
            chkState({tag, ".wait"}, 0, 0, 0, lives, 0);
            chk({tag, ".waitResp"}, int'(sIf.ShipRespawn), 0);
            tick();
        end
        chk({tag, ".respawn"}, int'(sIf.ShipRespawn), 1);
    endtask

    task automatic runInvuln(input string tag);
        for (int i = 0; i < 120; i++) begin
            chk({tag, ".blink"}, int'(sIf.ShipVisible), ((i / 4) % 2 == 0) ? 1 : 0);
            chk({tag, ".hit"}, int'(sIf.ShipHit), 0);
            chk({tag, ".resp"}, int'(sIf.ShipRespawn), (i == 0) ? 1 : 0);
            chk({tag, ".alive"}, int'(sIf.ShipAlive), 1);
            tick();
        end
    endtask

    initial begin
        sIf.ShipColl = 1'b0;
        sIf.Start    = 1'b0;
        #12;
        chkState("rst", 1, 1, 0, 3, 0);
        chk("rst.idx", int'(sIf.ExplodeIdx), 0);
        chk("rst.hit", int'(sIf.ShipHit), 0);
        chk("rst.resp", int'(sIf.ShipRespawn), 0);
        Reset = 1'b0;

        // 1: idle alive
        tick(10);
        chkState("idle", 1, 1, 0, 3, 0);
        chk("idle.hit", int'(sIf.ShipHit), 0);
        chk("idle.resp", int'(sIf.ShipRespawn), 0);

        // 2: first hit
        sIf.ShipColl = 1'b1;
        tick();
        sIf.ShipColl = 1'b0;
        chk("hit1.lives", int'(sIf.Lives), 2);
        chk("hit1.vis", int'(sIf.ShipVisible), 0);
        runExplodeRespawn("hit1", 2);

        // 3: held collision ignored through invulnerability
        sIf.ShipColl = 1'b1;
        runInvuln("inv1");
        chkState("inv1.end", 1, 1, 0, 2, 0);
        chk("inv1.endHit", int'(sIf.ShipHit), 0);
        tick();
        sIf.ShipColl = 1'b0;
        chk("hit2.pulse", int'(sIf.ShipHit), 1);
        chk("hit2.lives", int'(sIf.Lives), 1);
        runExplodeRespawn("hit2", 1);
        runInvuln("inv2");

        // 4: third hit leads to game over
        sIf.ShipColl = 1'b1;
        tick();
        sIf.ShipColl = 1'b0;
        chk("hit3.pulse", int'(sIf.ShipHit), 1);
        chk("hit3.lives", int'(sIf.Lives), 0);
        tick(16);
        chkState("go", 0, 0, 0, 0, 1);
        chk("go.resp", int'(sIf.ShipRespawn), 0);
        sIf.ShipColl = 1'b1;
        tick(20);
        sIf.ShipColl = 1'b0;
        chkState("goHold", 0, 0, 0, 0, 1);
        chk("goHold.resp", int'(sIf.ShipRespawn), 0);
        chk("goHold.hit", int'(sIf.ShipHit), 0);
        sIf.Start = 1'b1;
        tick();
        sIf.Start = 1'b0;
        chkState("restart", 1, 1, 0, 3, 0);
        runInvuln("inv3");

        // 5: Start ignored while alive and while exploding
        chkState("alive3", 1, 1, 0, 3, 0);
        sIf.Start = 1'b1;
        tick();
        sIf.Start = 1'b0;
        chkState("startAlive", 1, 1, 0, 3, 0);
        chk("startAlive.resp", int'(sIf.ShipRespawn), 0);
        sIf.ShipColl = 1'b1;
        tick();
        sIf.ShipColl = 1'b0;
        chk("hit4.lives", int'(sIf.Lives), 2);
        sIf.Start = 1'b1;
        tick();
        sIf.Start = 1'b0;
        chkState("startExp", 0, 0, 1, 2, 0);
        chk("startExp.idx", int'(sIf.ExplodeIdx), 0);
        chk("startExp.resp", int'(sIf.ShipRespawn), 0);
        chk("startExp.hit", int'(sIf.ShipHit), 0);
        tick(7);
        chk("exp.idx2", int'(sIf.ExplodeIdx), 2);

        // 6: asynchronous reset mid-explosion
        #2;
        Reset = 1'b1;
        #1;
        chkState("arst", 1, 1, 0, 3, 0);
        chk("arst.idx", int'(sIf.ExplodeIdx), 0);
        chk("arst.hit", int'(sIf.ShipHit), 0);
        tick();
        Reset = 1'b0;
        tick(3);
        chkState("postRst", 1, 1, 0, 3, 0);
        chk("postRst.hit", int'(sIf.ShipHit), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end
endmodule
